decode_issue_ctrl: RTL

Parametrised decode-to-execute issue stage. It holds the ID/EX pipeline register under a valid/ready handshake, and takes a control bundle from the combinational decoder. It adds three behaviours: a load-use interlock, a mult/div busy scoreboard that blocks HI/LO access and back-to-back MD ops, and pipeline flush. It sits between fetch/decode logic and the exe stage.

---
 rtl/decode_issue_ctrl_if.sv | 46 ++++
 rtl/decode_issue_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/decode_issue_ctrl_if.sv
// Decode-to-execute issue stage bus: front-end handshake, flush/exe backpressure and ID/EX register outputs.
// master drives the front end and exe_ready; slave is the issue stage itself.
interface decode_issue_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int RA_W   = 6,
  parameter int CTRL_W = 64
) ();
  logic              fe_valid;
  logic              fe_ready;
  logic [XLEN-1:0]   fe_pc;
  logic [CTRL_W-1:0] fe_ctrl;
  logic [RA_W-1:0]   fe_src1_addr;
  logic              fe_src1_en;
  logic [RA_W-1:0]   fe_src2_addr;
  logic              fe_src2_en;
  logic [RA_W-1:0]   fe_dst_addr;
  logic              fe_dst_en;
  logic              fe_is_load;
  logic              fe_md_start;
  logic              fe_hilo_read;
  logic              flush;
  logic              exe_ready;
  logic              de_valid;
  logic [XLEN-1:0]   de_pc;
  logic [CTRL_W-1:0] de_ctrl;
  logic [RA_W-1:0]   de_dst_addr;
  logic              de_dst_en;
  logic              de_is_load;
  logic              de_md_start;
  logic              md_busy;
  logic [31:0]       perf_stall_cnt;

  modport master (
    output fe_valid, fe_pc, fe_ctrl, fe_src1_addr, fe_src1_en, fe_src2_addr, fe_src2_en,
           fe_dst_addr, fe_dst_en, fe_is_load, fe_md_start, fe_hilo_read, flush, exe_ready,
    input  fe_ready, de_valid, de_pc, de_ctrl, de_dst_addr, de_dst_en, de_is_load,
           de_md_start, md_busy, perf_stall_cnt
  );

  modport slave (
    input  fe_valid, fe_pc, fe_ctrl, fe_src1_addr, fe_src1_en, fe_src2_addr, fe_src2_en,
           fe_dst_addr, fe_dst_en, fe_is_load, fe_md_start, fe_hilo_read, flush, exe_ready,
    output fe_ready, de_valid, de_pc, de_ctrl, de_dst_addr, de_dst_en, de_is_load,
           de_md_start, md_busy, perf_stall_cnt
  );
endinterface

// File: rtl/decode_issue_ctrl.sv
// ID/EX issue register with load-use interlock, mult/div busy scoreboard and flush.
// Define DECODE_PERF_CNT_EN to build the saturating stall-cycle counter on perf_stall_cnt.
module decode_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 6,
  parameter int CTRL_W     = 64,
  parameter int MD_LATENCY = 4
) (
  input  logic               clk,
  input  logic               reset,
  decode_issue_ctrl_if.slave bus
);
  localparam int              MD_CW   = $clog2(MD_LATENCY + 1);
  localparam logic [MD_CW-1:0] MD_LOAD = MD_CW'(MD_LATENCY);
  localparam logic [MD_CW-1:0] MD_ONE  = MD_CW'(1);
  localparam logic [MD_CW-1:0] MD_ZERO = MD_CW'(0);
  localparam logic [RA_W-1:0]  RA_ZERO = RA_W'(0);

  logic              r_de_valid;
  logic [XLEN-1:0]   r_de_pc;
  logic [CTRL_W-1:0] r_de_ctrl;
  logic [RA_W-1:0]   r_de_dst_addr;
  logic              r_de_dst_en;
  logic              r_de_is_load;
  logic              r_de_md_start;
  logic [MD_CW-1:0]  r_md_cnt;

  logic w_issue;
  logic w_src1_hit;
  logic w_src2_hit;
  logic w_lu_haz;
  logic w_md_busy;
  logic w_md_haz;
  logic w_hazard;
  logic w_fe_ready;
  logic w_accept;

  // Handshake and hazard detection; fe_ready deliberately ignores fe_valid.
  always_comb begin
    w_issue    = r_de_valid & bus.exe_ready;
    w_src1_hit = bus.fe_src1_en & (bus.fe_src1_addr == r_de_dst_addr);
    w_src2_hit = bus.fe_src2_en & (bus.fe_src2_addr == r_de_dst_addr);
    w_lu_haz   = r_de_valid & r_de_is_load & r_de_dst_en & (r_de_dst_addr != RA_ZERO)
               & (w_src1_hit | w_src2_hit);
    w_md_busy  = (r_md_cnt != MD_ZERO);
    // A held MD op blocks HI/LO users even before it issues and loads the counter.
    w_md_haz   = (bus.fe_hilo_read | bus.fe_md_start) & (w_md_busy | (r_de_valid & r_de_md_start));
    w_hazard   = w_lu_haz | w_md_haz;
    w_fe_ready = (~r_de_valid | bus.exe_ready) & ~w_hazard & ~bus.flush;
    w_accept   = bus.fe_valid & w_fe_ready;
  end

  // ID/EX register: flush beats accept, accept beats a plain issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de_valid    <= 1'b0;
      r_de_pc       <= {XLEN{1'b0}};
      r_de_ctrl     <= {CTRL_W{1'b0}};
      r_de_dst_addr <= RA_ZERO;
      r_de_dst_en   <= 1'b0;
      r_de_is_load  <= 1'b0;
      r_de_md_start <= 1'b0;
    end else if (bus.flush) begin
      r_de_valid <= 1'b0;
    end else if (w_accept) begin
      r_de_valid    <= 1'b1;
      r_de_pc       <= bus.fe_pc;
      r_de_ctrl     <= bus.fe_ctrl;
      r_de_dst_addr <= bus.fe_dst_addr;
      r_de_dst_en   <= bus.fe_dst_en;
      r_de_is_load  <= bus.fe_is_load;
      r_de_md_start <= bus.fe_md_start;
    end else if (w_issue) begin
      r_de_valid <= 1'b0;
    end else begin
      r_de_valid <= r_de_valid;
    end
  end

  // Mult/div busy counter; an MD op killed by flush never starts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_md_cnt <= MD_ZERO;
    end else if (w_issue & r_de_md_start & ~bus.flush) begin
      r_md_cnt <= MD_LOAD;
    end else if (r_md_cnt != MD_ZERO) begin
      r_md_cnt <= r_md_cnt - MD_ONE;
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_perf_cnt;

  // Saturating count of cycles a valid instruction was held back by a hazard or backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cnt <= 32'd0;
    end else if (bus.fe_valid & ~w_fe_ready & ~bus.flush & (r_perf_cnt != 32'hFFFF_FFFF)) begin
      r_perf_cnt <= r_perf_cnt + 32'd1;
    end else begin
      r_perf_cnt <= r_perf_cnt;
    end
  end

  assign bus.perf_stall_cnt = r_perf_cnt;
`else
  assign bus.perf_stall_cnt = 32'd0;
`endif

  assign bus.fe_ready    = w_fe_ready;
  assign bus.de_valid    = r_de_valid;
  assign bus.de_pc       = r_de_pc;
  assign bus.de_ctrl     = r_de_ctrl;
  assign bus.de_dst_addr = r_de_dst_addr;
  assign bus.de_dst_en   = r_de_dst_en;
  assign bus.de_is_load  = r_de_is_load;
  assign bus.de_md_start = r_de_md_start;
  assign bus.md_busy     = w_md_busy;
endmodule
